// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: mode encodings,
// FSM states and the digit-count helper used for elaboration checks.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of digit slices; 0 flags a DIGIT that does not tile WIDTH.
  function automatic int digit_count(input int width, input int digit);
    if (digit < 1 || digit > width) begin
      return 0;
    end else if ((width % digit) != 0) begin
      return 0;
    end else begin
      return width / digit;
    end
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple slice. Also reports the carry into its top
// bit so the caller can derive signed overflow on the final slice.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Ripple through the slice; c_msb keeps the carry entering the last bit.
  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb  = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock, LSB digit
// first, and publishes sum/carry/overflow with a one-cycle done pulse.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] final_sum,
  output logic             final_carry_out,
  output logic             overflow
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (N < 1) begin : g_illegal_digit
    $fatal(1, "serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t                 state;
  state_t                 state_next;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       res;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic                   last;
  logic [DIGIT-1:0]       dsum;
  logic                   dcout;
  logic                   dcmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  // New digits enter at the top, so after N shifts digit 0 sits at the LSB.
  assign res_cat  = {dsum, res};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt == CW'(N - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last ? IDLE : RUN;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh            <= '0;
      b_sh            <= '0;
      res             <= '0;
      carry           <= 1'b0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      final_sum       <= '0;
      final_carry_out <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1, the +1 entering as the initial carry.
            a_sh  <= data0;
            b_sh  <= (mode == MODE_ADD) ? data1 : ~data1;
            carry <= (mode == MODE_SUB);
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          res   <= res_next;
          carry <= dcout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            final_sum       <= res_next;
            final_carry_out <= dcout;
            overflow        <= dcmsb ^ dcout;
            done            <= 1'b1;
            busy            <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and table-driven checks of serial_adder at 8/2, plus a random sweep
// of 16-bit instances with DIGIT = 1, 4 and 16 against an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8;
  logic [7:0] a8, b8;
  logic       mode8;
  logic       busy8, done8, c8, v8;
  logic [7:0] sum8;

  logic [2:0]  start16;
  logic [15:0] a16, b16;
  logic        mode16;
  logic [2:0]  busy16, done16, c16, v16;
  logic [15:0] sum16_0, sum16_1, sum16_2;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .data0(a8), .data1(b8), .mode(mode8),
    .busy(busy8), .done(done8), .final_sum(sum8), .final_carry_out(c8), .overflow(v8)
  );
  serial_adder #(.WIDTH(16), .DIGIT(1)) dut16_1 (
    .clk(clk), .reset(reset), .start(start16[0]), .data0(a16), .data1(b16), .mode(mode16),
    .busy(busy16[0]), .done(done16[0]), .final_sum(sum16_0), .final_carry_out(c16[0]),
    .overflow(v16[0])
  );
  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16_4 (
    .clk(clk), .reset(reset), .start(start16[1]), .data0(a16), .data1(b16), .mode(mode16),
    .busy(busy16[1]), .done(done16[1]), .final_sum(sum16_1), .final_carry_out(c16[1]),
    .overflow(v16[1])
  );
  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16_16 (
    .clk(clk), .reset(reset), .start(start16[2]), .data0(a16), .data1(b16), .mode(mode16),
    .busy(busy16[2]), .done(done16[2]), .final_sum(sum16_2), .final_carry_out(c16[2]),
    .overflow(v16[2])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs [0:8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges are counted inclusive of the accepting edge; done is due at N+1.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      output int edges, output int busy_cycles);
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    edges = 1;
    busy_cycles = busy8 ? 1 : 0;
    while (!done8 && edges < 40) begin
      tick();
      edges++;
      if (busy8) busy_cycles++;
    end
  endtask

  function automatic logic [15:0] sel_sum(input int cfg);
    case (cfg)
      0:       return sum16_0;
      1:       return sum16_1;
      default: return sum16_2;
    endcase
  endfunction

  task automatic run16(input int cfg, input logic [15:0] a, input logic [15:0] b,
                       input logic m, output int edges);
    a16 = a; b16 = b; mode16 = m;
    start16 = 3'b001 << cfg;
    tick();
    start16 = 3'b000;
    edges = 1;
    while (!done16[cfg] && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges, bcyc, ndone;
    logic [15:0] ra, rb, es;
    logic        rm, ec, ev;
    int          nlist [3];

    vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    nlist[0] = 16; nlist[1] = 4; nlist[2] = 1;

    reset = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0;
    start16 = '0; a16 = '0; b16 = '0; mode16 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset sum", sum8, 8'h00);
    check("reset carry", c8, 1'b0);
    check("reset ovf", v8, 1'b0);
    check("reset busy16", busy16, 3'b000);

    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].m, edges, bcyc);
      check($sformatf("vec%0d done", i), done8, 1'b1);
      check($sformatf("vec%0d sum", i), sum8, vecs[i].s);
      check($sformatf("vec%0d carry", i), c8, vecs[i].c);
      check($sformatf("vec%0d ovf", i), v8, vecs[i].v);
      check($sformatf("vec%0d latency", i), edges, 5);
      check($sformatf("vec%0d busy cycles", i), bcyc, 4);
      check($sformatf("vec%0d busy in done", i), busy8, 1'b0);
      tick();
    end

    // Second start two cycles in is dropped; start in the done cycle is taken.
    a8 = 8'h10; b8 = 8'h20; mode8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("hs busy", busy8, 1'b1);
    tick(); tick();
    a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    edges = 4;
    while (!done8 && edges < 40) begin
      tick();
      edges++;
    end
    check("hs latency", edges, 5);
    check("hs sum", sum8, 8'h30);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("hs reissue busy", busy8, 1'b1);
    check("hs done pulse width", done8, 1'b0);
    check("hs sum holds", sum8, 8'h30);
    edges = 1;
    while (!done8 && edges < 40) begin
      tick();
      edges++;
    end
    check("hs2 latency", edges, 5);
    check("hs2 sum", sum8, 8'h02);
    tick();

    // Reset mid-operation aborts with no done pulse.
    a8 = 8'h7F; b8 = 8'h01; mode8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("rst busy", busy8, 1'b0);
    check("rst sum", sum8, 8'h00);
    check("rst ovf", v8, 1'b0);
    ndone = 0;
    repeat (3) begin
      tick();
      if (done8) ndone++;
    end
    #2 reset = 1'b0;
    repeat (6) begin
      tick();
      if (done8) ndone++;
    end
    check("rst no done", ndone, 0);
    check("rst still idle", busy8, 1'b0);
    run8(8'h03, 8'h04, 1'b0, edges, bcyc);
    check("post-rst sum", sum8, 8'h07);
    check("post-rst latency", edges, 5);
    tick();

    // Inputs scrambled every cycle while busy must not disturb the result.
    a8 = 8'h3C; b8 = 8'h0F; mode8 = 1'b1; start8 = 1'b1;
    tick();
    edges = 1;
    while (!done8 && edges < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = ~mode8; start8 = 1'($urandom);
      tick();
      edges++;
    end
    start8 = 1'b0;
    check("iso latency", edges, 5);
    check("iso sum", sum8, 8'h2D);
    check("iso carry", c8, 1'b1);
    check("iso ovf", v8, 1'b0);
    repeat (3) tick();
    check("hold sum", sum8, 8'h2D);
    check("hold done", done8, 1'b0);

    // Random sweep: independent arithmetic model for sum, carry, overflow.
    for (int cfg = 0; cfg < 3; cfg++) begin
      for (int k = 0; k < 1000; k++) begin
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
        if (!rm) begin
          es = ra + rb;
          ec = ({1'b0, ra} + {1'b0, rb}) > 17'h0FFFF;
          ev = (ra[15] == rb[15]) && (es[15] != ra[15]);
        end else begin
          es = ra - rb;
          ec = (ra >= rb);
          ev = (ra[15] != rb[15]) && (es[15] != ra[15]);
        end
        run16(cfg, ra, rb, rm, edges);
        check($sformatf("n%0d latency", nlist[cfg]), edges, nlist[cfg] + 1);
        check($sformatf("n%0d sum %h %h %b", nlist[cfg], ra, rb, rm), sel_sum(cfg), es);
        check($sformatf("n%0d carry %h %h %b", nlist[cfg], ra, rb, rm), c16[cfg], ec);
        check($sformatf("n%0d ovf %h %h %b", nlist[cfg], ra, rb, rm), v16[cfg], ev);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor: the multi-cycle successor to the team's 8-bit combinational add/sub unit. It takes two WIDTH-bit operands and a mode bit under a start/done handshake. It processes DIGIT bits per clock, LSB digit first, and returns sum, carry-out and signed overflow. It trades latency for area in datapaths where a full-width carry chain is too costly.

## Interface
- WIDTH, 8, operand/result width in bits
- DIGIT, 2, bits processed per cycle; must divide WIDTH, 1 ≤ DIGIT ≤ WIDTH; N = WIDTH/DIGIT

- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- data0  in  WIDTH  operand A; sampled on the accepting edge
- data1  in  WIDTH  operand B; sampled on the accepting edge
- mode  in  1  0 = add (A+B), 1 = subtract (A−B); sampled on the accepting edge
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; results valid
- final_sum  out  WIDTH  registered result
- final_carry_out  out  1  carry out of bit WIDTH−1; in subtract, 1 = no borrow
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN.
- IDLE, start=1 at an edge:
  - latch A=data0
  - latch B=mode ? ~data1 : data1
  - set carry=mode and digit counter=0
  - go to RUN; busy=1
- RUN, each edge:
  - add digit[cnt] of A and B plus carry; shift the digit result into the internal result register
  - update carry; increment cnt
- On the edge that processes digit N−1:
  - load final_sum, final_carry_out and overflow from the completed result
  - done=1 for one cycle; busy=0; return to IDLE
- overflow uses the carry into bit WIDTH−1, taken from the last digit slice.
- All inputs are ignored while busy=1; start during busy is dropped, not queued.
- Outputs hold their last values until the next done. They never show partial results.
- Arithmetic is modulo 2^WIDTH. Carry/overflow semantics are identical to the combinational unit for every WIDTH.
- DIGIT=WIDTH gives N=1: a single RUN cycle.

## Timing
- Reset values: busy=0, done=0, final_sum=0, final_carry_out=0, overflow=0; FSM=IDLE; counter and carry cleared.
- Reset takes effect immediately, asynchronously.
- Start accepted at edge k:
  - busy=1 after edge k
  - done=1 after edge k+N, for exactly one cycle; busy=0 in that same cycle
- Latency is N+1 edges from the accepting edge to done.
- start=1 in the done cycle is accepted (busy=0), so the back-to-back issue interval is N+1 cycles.
- Reset asserted mid-operation aborts it: no done, and outputs return to reset values.
- The first start after reset deassertion behaves normally.
- start held high continuously re-issues on every done cycle, capturing whatever data0/data1/mode are present.

## Structure
- Package adder_pkg holds:
  - MODE_ADD=1'b0, MODE_SUB=1'b1
  - state enum {IDLE, RUN}
  - a function computing N and asserting that DIGIT divides WIDTH
- Sub-module digit_adder:
  - DIGIT-bit ripple slice
  - inputs a, b, cin
  - outputs sum, cout, c_msb (carry into the slice's top bit)
  - purely combinational; instantiated once
- Top level holds the FSM, counter, operand shift registers, result shift register and output registers.
- An elaboration-time check rejects an illegal DIGIT.

## Test plan
- Add, signed overflow: WIDTH=8, DIGIT=2, mode=0, 0x7F+0x01.
  - final_sum=0x80, carry=0, overflow=1
  - done exactly 5 edges after the accepting edge; busy high for 4 cycles
- Add with carry, and subtract: 0xFF+0xFF → 0xFE/c1/v0; mode=1 cases:
  - 0x05−0x03 → 0x02/c1/v0
  - 0x00−0x01 → 0xFF/c0/v0
  - 0x80−0x01 → 0x7F/c1/v1
- Handshake: start 0x10+0x20, then start with 0x55/0x55 two cycles later.
  - The second request is ignored; result is 0x30.
  - start in the done cycle with 0x01+0x01 is accepted; the next result is 0x02.
- Reset mid-operation: assert reset 2 cycles into an 0x7F+0x01 add.
  - Outputs are immediately 0; no done pulse.
  - After release, 0x03+0x04 yields 0x07 with normal latency.
- Operand isolation: change data0/data1/mode every cycle while busy. The result matches the values latched at start.
- Parameter sweep: WIDTH=16 with DIGIT ∈ {1,4,16} (N=16,4,1).
  - 1000 random operand/mode sets per configuration
  - checked against a behavioural model for sum, carry, overflow and latency N+1
